// File: rtl/exec_pkg.sv
// Shared types and constants for the execute sequencing controller.
// Holds the FSM state encoding, condition codes, ALU opcodes and NZCV bit positions.
// Pure declarations; no logic.
package exec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // ARM-style condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // ALU opcodes; 1000..1011 are the compare/test class that never write back
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_RSB = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_RSC = 4'b0111;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_TEQ = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_BIC = 4'b1110;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Flag register bit positions: {Z, N, C, V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator: decides whether an instruction executes given NZCV.
// Latency: purely combinational.
// Backpressure: none.
module cond_eval
  import exec_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic z, n, c, v;
  assign z = flags[FLAG_Z];
  assign n = flags[FLAG_N];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition against the current flags
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_seq_ctrl.sv
// Sequencer for the execute ALU: accept, read operands/check cond, execute, write back.
// Latency: accept to in_ready again = 2 edges (skip), 3 (no write), 4+ (write-back).
// Backpressure: one instruction in flight; write-back waits in WB while wb_ready is low.
module exec_seq_ctrl
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_cond,
  input  logic              in_set_flags,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rn,
  input  logic [REG_AW-1:0] in_rm,
  input  logic              in_imm_sel,
  input  logic [DATA_W-1:0] in_imm,
  output logic [REG_AW-1:0] rf_rn_addr,
  output logic [REG_AW-1:0] rf_rm_addr,
  input  logic [DATA_W-1:0] rf_rn_data,
  input  logic [DATA_W-1:0] rf_rm_data,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_opr1,
  output logic [DATA_W-1:0] alu_opr2,
  output logic [DATA_W-1:0] alu_dep,
  output logic              alu_depi,
  output logic [3:0]        alu_nzcv_old,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_nzcv,
  input  logic              alu_is_write,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [3:0]        flags,
  output logic              busy,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  skipped
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t state_q, state_d;

  // Latched instruction fields
  logic [3:0]        op_q, cond_q;
  logic              set_flags_q, imm_sel_q;
  logic [REG_AW-1:0] rd_q, rn_q, rm_q;
  logic [DATA_W-1:0] imm_q;

  // ALU drive, write-back and architectural state
  logic [3:0]        alu_op_q;
  logic [DATA_W-1:0] alu_opr1_q, alu_opr2_q, alu_dep_q;
  logic              alu_depi_q;
  logic [REG_AW-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  retired_q, skipped_q;

  logic cond_pass;
  logic accept, issue, skip, exec_done, wb_load, retire;

  cond_eval u_cond_eval (
    .cond  (cond_q),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-state event strobes
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    issue     = 1'b0;
    skip      = 1'b0;
    exec_done = 1'b0;
    wb_load   = 1'b0;
    retire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (cond_pass) begin
          issue   = 1'b1;
          state_d = ST_EXEC;
        end else begin
          skip    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        exec_done = 1'b1;
        if (alu_is_write) begin
          wb_load = 1'b1;
          state_d = ST_WB;
        end else begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          retire  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Instruction latch, ALU operand issue, flag commit, write-back load, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q        <= '0;
      cond_q      <= '0;
      set_flags_q <= 1'b0;
      imm_sel_q   <= 1'b0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      imm_q       <= '0;
      alu_op_q    <= '0;
      alu_opr1_q  <= '0;
      alu_opr2_q  <= '0;
      alu_dep_q   <= '0;
      alu_depi_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      flags_q     <= '0;
      retired_q   <= '0;
      skipped_q   <= '0;
    end else begin
      if (accept) begin
        op_q        <= in_op;
        cond_q      <= in_cond;
        set_flags_q <= in_set_flags;
        imm_sel_q   <= in_imm_sel;
        rd_q        <= in_rd;
        rn_q        <= in_rn;
        rm_q        <= in_rm;
        imm_q       <= in_imm;
      end
      if (issue) begin
        alu_op_q   <= op_q;
        alu_opr1_q <= rf_rn_data;
        alu_opr2_q <= rf_rm_data;
        alu_dep_q  <= imm_q;
        alu_depi_q <= imm_sel_q;
      end
      if (exec_done && set_flags_q) flags_q <= alu_nzcv;
      if (wb_load) begin
        wb_addr_q <= rd_q;
        wb_data_q <= alu_result;
      end
      if (skip)   skipped_q <= skipped_q + CNT_ONE;
      if (retire) retired_q <= retired_q + CNT_ONE;
    end
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign wb_valid     = (state_q == ST_WB);
  assign rf_rn_addr   = rn_q;
  assign rf_rm_addr   = rm_q;
  assign alu_op       = alu_op_q;
  assign alu_opr1     = alu_opr1_q;
  assign alu_opr2     = alu_opr2_q;
  assign alu_dep      = alu_dep_q;
  assign alu_depi     = alu_depi_q;
  assign alu_nzcv_old = flags_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign flags        = flags_q;
  assign retired      = retired_q;
  assign skipped      = skipped_q;

endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed bench for exec_seq_ctrl with a behavioural ALU and register file.
// Counters are built 4 bits wide so the wrap can be reached in a few dozen instructions.
module tb_exec_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [3:0]        in_op = '0;
  logic [3:0]        in_cond = '0;
  logic              in_set_flags = 1'b0;
  logic [REG_AW-1:0] in_rd = '0, in_rn = '0, in_rm = '0;
  logic              in_imm_sel = 1'b0;
  logic [DATA_W-1:0] in_imm = '0;
  logic [REG_AW-1:0] rf_rn_addr, rf_rm_addr;
  logic [DATA_W-1:0] rf_rn_data, rf_rm_data;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_opr1, alu_opr2, alu_dep;
  logic              alu_depi;
  logic [3:0]        alu_nzcv_old;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_nzcv;
  logic              alu_is_write;
  logic              wb_valid;
  logic              wb_ready = 1'b1;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [3:0]        flags;
  logic              busy;
  logic [CNT_W-1:0]  retired, skipped;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  exec_seq_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_cond(in_cond),
    .in_set_flags(in_set_flags), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm_sel(in_imm_sel), .in_imm(in_imm),
    .rf_rn_addr(rf_rn_addr), .rf_rm_addr(rf_rm_addr),
    .rf_rn_data(rf_rn_data), .rf_rm_data(rf_rm_data),
    .alu_op(alu_op), .alu_opr1(alu_opr1), .alu_opr2(alu_opr2), .alu_dep(alu_dep),
    .alu_depi(alu_depi), .alu_nzcv_old(alu_nzcv_old),
    .alu_result(alu_result), .alu_nzcv(alu_nzcv), .alu_is_write(alu_is_write),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .busy(busy), .retired(retired), .skipped(skipped)
  );

  // Register file contents seen by the controller
  logic [DATA_W-1:0] rf [16];
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rf[1] = 32'h0000_000F;
    rf[2] = 32'h0000_00F0;
    rf[3] = 32'h7FFF_FFFF;
  end
  assign rf_rn_data = rf[rf_rn_addr];
  assign rf_rm_data = rf[rf_rm_addr];

  // Behavioural ALU: AND, ADD, CMP and a pass-through default
  logic [DATA_W-1:0] opb;
  logic [DATA_W:0]   sum;
  logic              c_out, v_out;
  always_comb begin
    opb          = alu_depi ? alu_dep : alu_opr2;
    sum          = '0;
    c_out        = alu_nzcv_old[1];
    v_out        = alu_nzcv_old[0];
    alu_result   = opb;
    alu_is_write = !(alu_op[3:2] == 2'b10);
    case (alu_op)
      4'b0000: alu_result = alu_opr1 & opb;
      4'b0100: begin
        sum        = {1'b0, alu_opr1} + {1'b0, opb};
        alu_result = sum[DATA_W-1:0];
        c_out      = sum[DATA_W];
        v_out      = (alu_opr1[31] == opb[31]) && (alu_result[31] != alu_opr1[31]);
      end
      4'b1010: begin
        sum        = {1'b0, alu_opr1} + {1'b0, ~opb} + 33'd1;
        alu_result = sum[DATA_W-1:0];
        c_out      = sum[DATA_W];
        v_out      = (alu_opr1[31] != opb[31]) && (alu_result[31] != alu_opr1[31]);
      end
      default: alu_result = opb;
    endcase
    alu_nzcv = {(alu_result == '0), alu_result[31], c_out, v_out};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and follow it until in_ready returns.
  // edges counts rising edges from the accept edge (inclusive) to in_ready high.
  task automatic run_instr(
    input  logic [3:0]        op,
    input  logic [3:0]        cond,
    input  logic              sf,
    input  logic [REG_AW-1:0] rd,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    input  logic              isel,
    input  logic [DATA_W-1:0] imm,
    output int                edges,
    output int                wb_at,
    output logic [DATA_W-1:0] wb_d,
    output logic [REG_AW-1:0] wb_a
  );
    in_op = op; in_cond = cond; in_set_flags = sf;
    in_rd = rd; in_rn = rn; in_rm = rm; in_imm_sel = isel; in_imm = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    edges = 1;
    wb_at = 0;
    wb_d  = '0;
    wb_a  = '0;
    while (!in_ready && edges < 30) begin
      if (wb_valid && wb_at == 0) begin
        wb_at = edges;
        wb_d  = wb_data;
        wb_a  = wb_addr;
      end
      step();
      edges++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
  endtask

  int                edges, wb_at;
  logic [DATA_W-1:0] wbd, hold_d;
  logic [REG_AW-1:0] wba, hold_a;

  initial begin
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_flags", flags, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_retired", retired, 0);
    check("rst_skipped", skipped, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_depi", alu_depi, 0);
    check("rst_wb_data", wb_data, 0);

    // AND r1,r2 -> 0x0F & 0xF0 = 0, Z set
    run_instr(4'b0000, 4'b1110, 1'b1, 4'd5, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("and_wb_at", wb_at, 3);
    check("and_edges", edges, 4);
    check("and_wb_data", wbd, 32'h0);
    check("and_wb_addr", wba, 5);
    check("and_flags", flags, 4'b1000);
    check("and_retired", retired, 1);

    // ADD r3 + #1 -> 0x80000000, N=1 C=0 V=1 Z=0
    run_instr(4'b0100, 4'b1110, 1'b1, 4'd6, 4'd3, 4'd0, 1'b1, 32'd1, edges, wb_at, wbd, wba);
    check("add_depi", alu_depi, 1);
    check("add_dep", alu_dep, 1);
    check("add_wb_data", wbd, 32'h8000_0000);
    check("add_wb_addr", wba, 6);
    check("add_flags", flags, 4'b0101);
    check("add_edges", edges, 4);
    check("add_retired", retired, 2);

    // EQ with Z=0 -> skipped, ALU untouched
    run_instr(4'b0000, 4'b0000, 1'b1, 4'd7, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("eq_edges", edges, 2);
    check("eq_no_wb", wb_at, 0);
    check("eq_skipped", skipped, 1);
    check("eq_alu_op_held", alu_op, 4'b0100);
    check("eq_flags", flags, 4'b0101);
    check("eq_retired", retired, 2);

    // NV -> always skipped
    run_instr(4'b0000, 4'b1111, 1'b1, 4'd7, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("nv_edges", edges, 2);
    check("nv_no_wb", wb_at, 0);
    check("nv_skipped", skipped, 2);

    // CMP without set_flags: no write-back, flags untouched
    run_instr(4'b1010, 4'b1110, 1'b0, 4'd8, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("cmp_edges", edges, 3);
    check("cmp_no_wb", wb_at, 0);
    check("cmp_flags", flags, 4'b0101);
    check("cmp_retired", retired, 3);

    // MI passes (N=1): ADD r1+r2 = 0xFF to r9
    run_instr(4'b0100, 4'b0100, 1'b0, 4'd9, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("mi_edges", edges, 4);
    check("mi_wb_data", wbd, 32'hFF);
    check("mi_retired", retired, 4);

    // LT fails (N==V) -> skipped
    run_instr(4'b0100, 4'b1011, 1'b0, 4'd9, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("lt_edges", edges, 2);
    check("lt_skipped", skipped, 3);

    // Write-back stall, then reset while stalled
    wb_ready = 1'b0;
    in_op = 4'b0100; in_cond = 4'b1110; in_set_flags = 1'b0;
    in_rd = 4'd10; in_rn = 4'd3; in_rm = 4'd1; in_imm_sel = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10 && !wb_valid; i++) step();
    check("stall_wb_valid", wb_valid, 1);
    hold_d = wb_data;
    hold_a = wb_addr;
    check("stall_wb_data", hold_d, 32'h8000_000E);
    check("stall_wb_addr", hold_a, 10);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid_held", wb_valid, 1);
      check("stall_data_held", wb_data, 32'h8000_000E);
      check("stall_addr_held", wb_addr, 10);
      check("stall_in_ready", in_ready, 0);
      check("stall_retired", retired, 4);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    wb_ready = 1'b1;
    check("rst_mid_wb_valid", wb_valid, 0);
    check("rst_mid_flags", flags, 0);
    check("rst_mid_retired", retired, 0);
    check("rst_mid_in_ready", in_ready, 1);

    // Counter wrap: 15 retires reach the top, the 16th wraps to zero
    for (int i = 0; i < 15; i++)
      run_instr(4'b1010, 4'b1110, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("wrap_top", retired, 4'hF);
    run_instr(4'b1010, 4'b1110, 1'b0, 4'd0, 4'd1, 4'd2, 1'b0, 32'd0, edges, wb_at, wbd, wba);
    check("wrap_zero", retired, 4'h0);
    check("wrap_skipped", skipped, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
